ochiba_rv32im_muldiv: RTL and testbench

OCHIBA_RV32IM_MULDIV -- requirements
Module: ochiba_rv32im_muldiv

---
 rtl/ochiba_rv32im_muldiv_if.sv | 22 ++
 rtl/ochiba_rv32im_muldiv.sv | 139 +++++++++++++
 tb/tb_ochiba_rv32im_muldiv.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ochiba_rv32im_muldiv_if.sv
// Issue/result bundle between the pipeline controller and the RV32M multiply/divide unit.
// The controller holds the master side; the unit holds the slave side.
interface ochiba_rv32im_muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        Exnow;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  Exnow, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output Exnow, done, result
    );
endinterface

// File: rtl/ochiba_rv32im_muldiv.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on operand magnitudes,
// with the sign fixed up afterwards. Every op, including the special cases, completes at the same fixed latency.
module ochiba_rv32im_muldiv (
    input  logic                      clk,
    input  logic                      reset,
    ochiba_rv32im_muldiv_if.slave     bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [63:0] acc;
    logic        neg;
    logic        spec;
    logic [31:0] spec_val;
    logic [31:0] result_q;

    // Operand decode at issue
    logic        f_div, a_signed, b_signed, sa, sb;
    logic [31:0] mag_a, mag_b;
    logic        neg_n, divz, ovf;
    logic [31:0] spec_val_n;

    always_comb begin
        f_div    = bus.funct3[2];
        a_signed = (bus.funct3 == F_MUL)  || (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                   (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
        b_signed = (bus.funct3 == F_MUL)  || (bus.funct3 == F_MULH) ||
                   (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
        sa       = a_signed & bus.rs1[31];
        sb       = b_signed & bus.rs2[31];
        mag_a    = sa ? (32'd0 - bus.rs1) : bus.rs1;
        mag_b    = sb ? (32'd0 - bus.rs2) : bus.rs2;
        // Remainder takes the dividend's sign; quotient and product take the xor.
        neg_n    = (f_div && bus.funct3[1]) ? sa : (sa ^ sb);
        divz     = f_div && (bus.rs2 == 32'd0);
        ovf      = f_div && !bus.funct3[0] &&
                   (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
        spec_val_n = 32'd0;
        if (divz)
            spec_val_n = bus.funct3[1] ? bus.rs1 : 32'hFFFF_FFFF;
        else if (ovf)
            spec_val_n = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration step; acc holds {hi,lo} for mul and {rem,quo} for div.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [63:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        div_sh   = acc[63:31];
        div_diff = {1'b0, div_sh} - {2'b00, opa};
        if (div_diff[33])
            div_next = {div_sh[31:0], acc[30:0], 1'b0};
        else
            div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end

    // Sign correction and word select
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] fix_val;

    always_comb begin
        prod = neg ? (64'd0 - acc) : acc;
        quo  = neg ? (32'd0 - acc[31:0])  : acc[31:0];
        rem  = neg ? (32'd0 - acc[63:32]) : acc[63:32];
        if (spec)
            fix_val = spec_val;
        else if (op[2])
            fix_val = op[1] ? rem : quo;
        else if (op == F_MUL)
            fix_val = prod[31:0];
        else
            fix_val = prod[63:32];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            result_q <= 32'd0;
            op       <= 3'd0;
            opa      <= 32'd0;
            acc      <= 64'd0;
            neg      <= 1'b0;
            spec     <= 1'b0;
            spec_val <= 32'd0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op       <= bus.funct3;
                        opa      <= f_div ? mag_b : mag_a;
                        acc      <= {32'd0, f_div ? mag_a : mag_b};
                        neg      <= neg_n;
                        spec     <= divz | ovf;
                        spec_val <= spec_val_n;
                        cnt      <= 6'd0;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_val;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Exnow  = ((state == S_IDLE) && bus.start) || (state == S_CALC) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_ochiba_rv32im_muldiv.sv
// Directed bench for the RV32M unit: an age-counting reference model checked every cycle,
// plus literal expectations on the documented vectors and control scenarios.
module tb_ochiba_rv32im_muldiv;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ochiba_rv32im_muldiv_if bus();

    ochiba_rv32im_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa, sb;
        logic   ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        case (f)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Model: an accepted op ages one per cycle; done and the new result appear at age 34.
    bit          busy = 1'b0;
    int          age = 0;
    logic [31:0] pend = 32'd0;
    logic [31:0] exp_res = 32'd0;

    always @(posedge clk) begin
        if (!reset) begin
            busy    <= 1'b0;
            age     <= 0;
            exp_res <= 32'd0;
        end else if (bus.flush) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (age == 34) busy <= 1'b0;
            else begin
                age <= age + 1;
                if (age == 33) exp_res <= pend;
            end
        end else if (bus.start) begin
            busy <= 1'b1;
            age  <= 1;
            pend <= ref_op(bus.funct3, bus.rs1, bus.rs2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("Exnow",  32'(bus.Exnow), 32'((!busy && bus.start) || (busy && age < 34)));
            chk("done",   32'(bus.done),  32'(busy && age == 34));
            chk("result", bus.result, exp_res);
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit uselit, input string nm);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = f; bus.rs1 = a; bus.rs2 = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                chk({nm, " latency"}, 32'(k), 32'd34);
                if (uselit) chk(nm, bus.result, exp);
                seen = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (seen) break;
        end
        if (!seen) chk({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [31:0] vals [8];
        vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'h1234_5678, 32'hDEAD_BEEF};

        bus.start = 1'b0; bus.funct3 = 3'd0; bus.rs1 = 32'd0; bus.rs2 = 32'd0; bus.flush = 1'b0;

        // Model pins
        chk("model MULHSU", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model DIV",    ref_op(3'd4, 32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFD);
        chk("model REM",    ref_op(3'd6, 32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);
        chk("model REM/0",  ref_op(3'd6, 32'd5, 32'd0),                 32'd5);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset result", dut.bus.result, 32'd0);
        chk("reset done",   32'(bus.done),  32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, "MUL");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1, "MULH");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "MULHU");
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "MULHSU");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1, "DIV");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1, "REM");
        run_op(3'd5, 32'd100,        32'd7,         32'd14,        1, "DIVU");
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         1, "REMU");
        run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, "DIVU/0");
        run_op(3'd6, 32'd5,          32'd0,         32'd5,         1, "REM/0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, "REM ovf");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "MULHU pre-flush");

        // Flush in CALC cycle 10
        dones = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd4;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (k == 11) chk("flush Exnow", 32'(bus.Exnow), 32'd0);
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.flush = (k + 1 == 10);
        end
        bus.flush = 1'b0;
        chk("flush no done", 32'(dones), 32'd0);
        chk("flush result kept", bus.result, 32'hFFFF_FFFE);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1, "MUL after flush");

        // Starts during CALC and DONE are ignored
        dones = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0) || (k == 5) || (k == 34);
            bus.funct3 = (k == 0) ? 3'd5 : 3'd0;
            bus.rs1    = (k == 0) ? 32'd100 : 32'd2;
            bus.rs2    = (k == 0) ? 32'd7   : 32'd2;
            @(negedge clk);
            if (bus.done) begin
                dones++;
                chk("ignore latency", 32'(k), 32'd34);
                chk("ignore result", bus.result, 32'd14);
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ignore single done", 32'(dones), 32'd1);

        // Reset mid-CALC
        dones = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1 = 32'd7; bus.rs2 = 32'd3;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
            @(posedge clk); #1;
            bus.start = 1'b0;
            reset = !(k + 1 == 15);
        end
        reset = 1'b1;
        chk("reset no done", 32'(dones), 32'd0);
        chk("reset result", bus.result, 32'd0);

        // Mixed ops checked by the model only
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 7)] : $urandom;
            run_op(f, a, b, 32'd0, 0, "mixed");
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
